// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with optional zero entry, sweep-clear engine and sticky dropped-write flag.
// Optional same-cycle write-through forwarding is enabled by defining REG_FILE_PARAM_BYPASS_EN.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    IDLE_S  = 1'b0,
    SWEEP_S = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              busy_r;
  logic              clr_done_r;
  logic              wr_drop_r;
  logic              zero_hit_s;
  logic              write_ok_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;

  // Classify the write port: writes to the hardwired zero entry are dropped silently
  always_comb begin
    zero_hit_s = 1'b0;
    if ((ZERO_REG != 0) && (wa3 == {ADDR_W{1'b0}})) begin
      zero_hit_s = 1'b1;
    end else begin
      zero_hit_s = 1'b0;
    end
    write_ok_s = we3 && (state_r == IDLE_S) && !zero_hit_s;
  end

  // Read port 1 mux
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
`ifdef REG_FILE_PARAM_BYPASS_EN
    if (write_ok_s && (ra1 == wa3)) begin
      rd1_s = wd3;
    end else if ((ZERO_REG != 0) && (ra1 == {ADDR_W{1'b0}})) begin
      rd1_s = {DATA_W{1'b0}};
    end else begin
      rd1_s = mem_r[ra1];
    end
`else
    if ((ZERO_REG != 0) && (ra1 == {ADDR_W{1'b0}})) begin
      rd1_s = {DATA_W{1'b0}};
    end else begin
      rd1_s = mem_r[ra1];
    end
`endif
  end

  // Read port 2 mux
  always_comb begin
    rd2_s = {DATA_W{1'b0}};
`ifdef REG_FILE_PARAM_BYPASS_EN
    if (write_ok_s && (ra2 == wa3)) begin
      rd2_s = wd3;
    end else if ((ZERO_REG != 0) && (ra2 == {ADDR_W{1'b0}})) begin
      rd2_s = {DATA_W{1'b0}};
    end else begin
      rd2_s = mem_r[ra2];
    end
`else
    if ((ZERO_REG != 0) && (ra2 == {ADDR_W{1'b0}})) begin
      rd2_s = {DATA_W{1'b0}};
    end else begin
      rd2_s = mem_r[ra2];
    end
`endif
  end

  // Storage, sweep FSM and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE_S;
      ptr_r      <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
      clr_done_r <= 1'b0;
      wr_drop_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      clr_done_r <= 1'b0;
      case (state_r)
        IDLE_S: begin
          if (write_ok_s) begin
            mem_r[wa3] <= wd3;
          end
          if (clr_req) begin
            state_r   <= SWEEP_S;
            ptr_r     <= {ADDR_W{1'b0}};
            busy_r    <= 1'b1;
            wr_drop_r <= 1'b0;
          end
        end
        SWEEP_S: begin
          mem_r[ptr_r] <= {DATA_W{1'b0}};
          if (we3 && !zero_hit_s) begin
            wr_drop_r <= 1'b1;
          end
          // Last entry: finish without wrapping the pointer
          if (ptr_r == {ADDR_W{1'b1}}) begin
            state_r    <= IDLE_S;
            busy_r     <= 1'b0;
            clr_done_r <= 1'b1;
          end else begin
            ptr_r <= ptr_r + ADDR_W'(1);
          end
        end
        default: begin
          state_r <= IDLE_S;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rd1      = rd1_s;
  assign rd2      = rd2_s;
  assign busy     = busy_r;
  assign clr_done = clr_done_r;
  assign wr_drop  = wr_drop_r;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus
// and are compared every cycle against an array-based reference model; honours REG_FILE_PARAM_BYPASS_EN.
`timescale 1ns/1ps
module tb_reg_file_param;

  logic       clk;
  logic       rst;
  logic       we3;
  logic [2:0] wa3;
  logic [7:0] wd3;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic       clr_req;
  logic [7:0] rd1_a, rd2_a, rd1_z, rd2_z;
  logic       busy_a, done_a, drop_a, busy_z, done_z, drop_z;

  int n_chk = 0;
  int n_err = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  // Reference model, index 0 = plain instance, index 1 = zero-entry instance
  logic [7:0] m_mem [2][8];
  bit         m_busy [2];
  int         m_cleared [2];
  bit         m_done [2];
  bit         m_drop [2];

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_a), .rd2(rd2_a), .clr_req(clr_req), .busy(busy_a), .clr_done(done_a), .wr_drop(drop_a)
  );

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_z), .rd2(rd2_z), .clr_req(clr_req), .busy(busy_z), .clr_done(done_z), .wr_drop(drop_z)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
      m_busy[k] = 1'b0;
      m_cleared[k] = 0;
      m_done[k] = 1'b0;
      m_drop[k] = 1'b0;
    end
  endtask

  function automatic logic [7:0] exp_rd(input int k, input logic [2:0] ra);
    bit zhit_w;
    zhit_w = (k == 1) && (wa3 == 3'd0);
`ifdef REG_FILE_PARAM_BYPASS_EN
    if (!m_busy[k] && we3 && !zhit_w && (ra == wa3)) return wd3;
`endif
    if ((k == 1) && (ra == 3'd0)) return 8'h00;
    return m_mem[k][ra];
  endfunction

  task automatic model_edge(input int k);
    bit zhit;
    zhit = (k == 1) && (wa3 == 3'd0);
    m_done[k] = 1'b0;
    if (!m_busy[k]) begin
      if (we3 && !zhit) m_mem[k][wa3] = wd3;
      if (clr_req) begin
        m_busy[k] = 1'b1;
        m_cleared[k] = 0;
        m_drop[k] = 1'b0;
      end
    end else begin
      if (we3 && !zhit) m_drop[k] = 1'b1;
      m_mem[k][m_cleared[k]] = 8'h00;
      m_cleared[k]++;
      if (m_cleared[k] == 8) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b1;
      end
    end
  endtask

  // One clock: compare everything mid-cycle, then advance the model on the rising edge
  task automatic step();
    @(negedge clk);
    check("a_rd1", rd1_a, exp_rd(0, ra1));
    check("a_rd2", rd2_a, exp_rd(0, ra2));
    check("a_busy", busy_a, m_busy[0]);
    check("a_done", done_a, m_done[0]);
    check("a_drop", drop_a, m_drop[0]);
    check("z_rd1", rd1_z, exp_rd(1, ra1));
    check("z_rd2", rd2_z, exp_rd(1, ra2));
    check("z_busy", busy_z, m_busy[1]);
    check("z_done", done_z, m_done[1]);
    check("z_drop", drop_z, m_drop[1]);
    if (busy_a) busy_cycles++;
    if (done_a) done_pulses++;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b0; we3 = 1'b0; wa3 = 3'd0; wd3 = 8'h00; ra1 = 3'd0; ra2 = 3'd0; clr_req = 1'b0;
    model_reset();
    #5;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_drop", drop_a, 1'b0);
    check("rst_rd1", rd1_a, 8'h00);
    #30 rst = 1'b1;
    @(posedge clk); #1;

    // Basic write/read
    we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hA5; step();
    wa3 = 3'd6; wd3 = 8'h5A; step();
    we3 = 1'b0; ra1 = 3'd3; ra2 = 3'd6; #1;
    check("wr_rd1", rd1_a, 8'hA5);
    check("wr_rd2", rd2_a, 8'h5A);
    ra2 = 3'd3; #1;
    check("same_rd1", rd1_a, 8'hA5);
    check("same_rd2", rd2_a, 8'hA5);
    step();

    // Zero entry
    we3 = 1'b1; wa3 = 3'd0; wd3 = 8'h33; step();
    we3 = 1'b0; ra1 = 3'd0; #1;
    check("zero_a_rd1", rd1_a, 8'h33);
    check("zero_z_rd1", rd1_z, 8'h00);
    check("zero_z_drop", drop_z, 1'b0);
    step();

`ifdef REG_FILE_PARAM_BYPASS_EN
    we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h9C; ra2 = 3'd4; #1;
    check("byp_rd2", rd2_a, 8'h9C);
    step();
    we3 = 1'b0;
`endif

    // Fill with 0xFF and sweep
    we3 = 1'b1; wd3 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      wa3 = 3'(i);
      step();
    end
    we3 = 1'b0; ra1 = 3'd2; ra2 = 3'd5;
    clr_req = 1'b1; busy_cycles = 0; done_pulses = 0;
    step();
    clr_req = 1'b0;
    steps(4);
    check("mid_rd_cleared", rd1_a, 8'h00);
    check("mid_rd_old", rd2_a, 8'hFF);
    we3 = 1'b1; wa3 = 3'd7; wd3 = 8'h77; ra2 = 3'd7; #1;
    check("busy_no_fwd", rd2_a, 8'hFF);
    step();
    we3 = 1'b0;
    steps(3);
    check("end_busy", busy_a, 1'b0);
    check("end_done", done_a, 1'b1);
    steps(2);
    check("busy_len", busy_cycles, 8);
    check("done_count", done_pulses, 1);
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); #1;
      check("post_sweep_rd", rd1_a, 8'h00);
    end
    check("drop_set", drop_a, 1'b1);
    clr_req = 1'b1; step();
    clr_req = 1'b0;
    check("drop_cleared", drop_a, 1'b0);
    steps(9);

    // Request held high re-arms every 9 cycles
    clr_req = 1'b1; done_pulses = 0;
    steps(20);
    clr_req = 1'b0;
    check("held_done_count", done_pulses, 2);
    steps(10);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      we3 = 1'($urandom_range(0, 1));
      wa3 = 3'($urandom_range(0, 7));
      wd3 = 8'($urandom);
      ra1 = 3'($urandom_range(0, 7));
      ra2 = 3'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 19) == 0);
      step();
    end
    we3 = 1'b0; clr_req = 1'b0;
    steps(10);

    // Asynchronous reset in the middle of a sweep
    we3 = 1'b1; wd3 = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      wa3 = 3'(i);
      step();
    end
    we3 = 1'b0; clr_req = 1'b1; step();
    clr_req = 1'b0;
    steps(3);
    rst = 1'b0; #1;
    check("arst_busy_a", busy_a, 1'b0);
    check("arst_busy_z", busy_z, 1'b0);
    check("arst_done", done_a, 1'b0);
    check("arst_drop", drop_a, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i); #1;
      check("arst_rd1", rd1_a, 8'h00);
      check("arst_rd2", rd2_z, 8'h00);
    end
    model_reset();
    rst = 1'b1;
    steps(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
